// File: rtl/tpu_program_memory.sv
// Program store for the 4-bit core: zero-latency fetch port plus a nibble-serial loader.
// Optional TPU_PMEM_CHECKSUM_EN adds a CHECKSUM output summing every byte written by a load.
module tpu_program_memory #(
    parameter int unsigned ADDR_W = 6,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned DEPTH  = 64
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic                LD_START,
    input  logic                LD_VALID,
    input  logic [DATA_W/2-1:0] LD_NIBBLE,
    input  logic                LD_LAST,
    output logic                LD_READY,
    output logic                CPU_RUN,
    input  logic [ADDR_W-1:0]   MEM_ADDR,
    output logic [DATA_W-1:0]   MEM_INPUT,
    output logic                LD_BUSY
`ifdef TPU_PMEM_CHECKSUM_EN
    ,
    output logic [7:0]          CHECKSUM
`endif
);

    localparam int unsigned NIB_W = DATA_W / 2;

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StLoad = 2'd1;
    localparam logic [1:0] StRun  = 2'd2;

    localparam logic [ADDR_W-1:0] LastAddr = ADDR_W'(DEPTH - 1);

    logic [1:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              phase_q, phase_d;   // 0 = expecting low nibble
    logic [NIB_W-1:0]  hold_q, hold_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic              xfer;
    logic              we;
    logic [DATA_W-1:0] wdata;

    assign LD_READY = (state_q == StLoad) & ~LD_START;
    assign xfer     = LD_VALID & LD_READY;
    assign CPU_RUN  = (state_q == StRun);
    assign LD_BUSY  = (state_q == StLoad);
    assign wdata    = {LD_NIBBLE, hold_q};

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        phase_d = phase_q;
        hold_d  = hold_q;
        we      = 1'b0;
        // LD_START restarts from any state and takes precedence over a nibble transfer.
        if (LD_START) begin
            state_d = StLoad;
            addr_d  = '0;
            phase_d = 1'b0;
        end else if (xfer) begin
            if (!phase_q) begin
                hold_d  = LD_NIBBLE;
                phase_d = 1'b1;
            end else begin
                we      = 1'b1;
                phase_d = 1'b0;
                addr_d  = addr_q + 1'b1;
                if (LD_LAST || addr_q == LastAddr) begin
                    state_d = StRun;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= StIdle;
            addr_q  <= '0;
            phase_q <= 1'b0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            phase_q <= phase_d;
            hold_q  <= hold_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we) begin
            mem_q[addr_q] <= wdata;
        end
    end

    assign MEM_INPUT = (state_q == StRun) ? mem_q[MEM_ADDR] : '0;

`ifdef TPU_PMEM_CHECKSUM_EN
    logic [7:0] checksum_q;

    always_ff @(posedge CLK) begin
        if (RESET || LD_START) begin
            checksum_q <= 8'h00;
        end else if (we) begin
            checksum_q <= checksum_q + wdata[7:0];
        end
    end

    assign CHECKSUM = checksum_q;
`endif

endmodule

// File: tb/tb_tpu_program_memory.sv
// Self-checking bench for tpu_program_memory: loader handshake, run control and fetch contents.
// Fetch expectations go through a queue scoreboard; fixed cases come from a vector table.
module tb_tpu_program_memory;

    logic       CLK = 1'b0;
    logic       RESET;
    logic       LD_START;
    logic       LD_VALID;
    logic [3:0] LD_NIBBLE;
    logic       LD_LAST;
    logic       LD_READY;
    logic       CPU_RUN;
    logic [5:0] MEM_ADDR;
    logic [7:0] MEM_INPUT;
    logic       LD_BUSY;
`ifdef TPU_PMEM_CHECKSUM_EN
    logic [7:0] CHECKSUM;
`endif

    tpu_program_memory dut (
        .CLK       (CLK),
        .RESET     (RESET),
        .LD_START  (LD_START),
        .LD_VALID  (LD_VALID),
        .LD_NIBBLE (LD_NIBBLE),
        .LD_LAST   (LD_LAST),
        .LD_READY  (LD_READY),
        .CPU_RUN   (CPU_RUN),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_INPUT (MEM_INPUT),
        .LD_BUSY   (LD_BUSY)
`ifdef TPU_PMEM_CHECKSUM_EN
        ,
        .CHECKSUM  (CHECKSUM)
`endif
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [5:0] addr;
        logic [7:0] exp;
    } vec_t;

    int         n_cmp = 0;
    int         n_err = 0;
    logic [7:0] model [64];
    logic [7:0] exp_q [$];
    vec_t       vecs [$];
    logic [7:0] ck;

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %02h expected %02h", name, got, exp);
        end
    endtask

    task automatic chk_ctl(input string tag, input logic run, input logic busy, input logic rdy);
        chk({tag, ".cpu_run"}, {7'd0, CPU_RUN}, {7'd0, run});
        chk({tag, ".ld_busy"}, {7'd0, LD_BUSY}, {7'd0, busy});
        chk({tag, ".ld_ready"}, {7'd0, LD_READY}, {7'd0, rdy});
    endtask

    task automatic chk_sum(input string tag, input logic [7:0] exp);
`ifdef TPU_PMEM_CHECKSUM_EN
        chk({tag, ".checksum"}, CHECKSUM, exp);
`else
        if (exp === 8'hxx) $display("unreachable %s", tag);
`endif
    endtask

    // Expected value queued when the address is driven, popped when MEM_INPUT has settled.
    task automatic fetch_chk(input logic [5:0] a, input logic [7:0] e);
        logic [7:0] want;
        MEM_ADDR = a;
        exp_q.push_back(e);
        #1;
        want = exp_q.pop_front();
        chk($sformatf("fetch[%0d]", a), MEM_INPUT, want);
    endtask

    task automatic fetch_all(input logic run);
        for (int a = 0; a < 64; a++) begin
            fetch_chk(6'(a), run ? model[a] : 8'h00);
        end
    endtask

    task automatic pulse_start;
        LD_START = 1'b1;
        @(posedge CLK);
        #1;
        LD_START = 1'b0;
        @(negedge CLK);
    endtask

    task automatic send_nib(input logic [3:0] n, input logic last, input int gap);
        int k;
        LD_VALID = 1'b0;
        repeat (gap) @(negedge CLK);
        LD_VALID  = 1'b1;
        LD_NIBBLE = n;
        LD_LAST   = last;
        k = 0;
        while (!LD_READY && k < 20) begin
            @(negedge CLK);
            k++;
        end
        if (!LD_READY) chk("ready_timeout", {7'd0, LD_READY}, 8'h01);
        else @(posedge CLK);
        #1;
        LD_VALID = 1'b0;
        LD_LAST  = 1'b0;
        @(negedge CLK);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last, input int gapmax);
        send_nib(b[3:0], 1'b0, int'($urandom_range(0, gapmax)));
        send_nib(b[7:4], last, int'($urandom_range(0, gapmax)));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        RESET     = 1'b1;
        LD_START  = 1'b0;
        LD_VALID  = 1'b0;
        LD_NIBBLE = 4'h0;
        LD_LAST   = 1'b0;
        MEM_ADDR  = 6'd0;
        for (int a = 0; a < 64; a++) model[a] = 8'h00;

        // Reset
        repeat (2) @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk_ctl("reset", 1'b0, 1'b0, 1'b0);
        fetch_all(1'b0);
        chk_sum("reset", 8'h00);

        // Short load terminated by LD_LAST
        pulse_start();
        chk_ctl("short_start", 1'b0, 1'b1, 1'b1);
        fetch_chk(6'd0, 8'h00);
        send_nib(4'h3, 1'b0, 0);
        send_nib(4'hA, 1'b0, 0);
        send_nib(4'hF, 1'b1, 0);   // LD_LAST on a low nibble is ignored
        chk_ctl("short_pre_last", 1'b0, 1'b1, 1'b1);
        send_nib(4'hC, 1'b1, 0);
        chk_ctl("short_done", 1'b1, 1'b0, 1'b0);
        model[0] = 8'hA3;
        model[1] = 8'hCF;
        vecs.push_back('{addr: 6'd0, exp: 8'hA3});
        vecs.push_back('{addr: 6'd1, exp: 8'hCF});
        vecs.push_back('{addr: 6'd2, exp: 8'h00});
        vecs.push_back('{addr: 6'd63, exp: 8'h00});
        foreach (vecs[i]) fetch_chk(vecs[i].addr, vecs[i].exp);
        chk_sum("short", 8'h72);

        // Full gap-free load ending at the top address
        pulse_start();
        ck = 8'h00;
        for (int i = 0; i < 64; i++) begin
            if (i == 63) chk_ctl("full_pre_top", 1'b0, 1'b1, 1'b1);
            send_byte(8'(i), 1'b0, 0);
            model[i] = 8'(i);
            ck = ck + 8'(i);
        end
        chk_ctl("full_done", 1'b1, 1'b0, 1'b0);
        LD_VALID  = 1'b1;
        LD_NIBBLE = 4'h7;
        #1;
        chk("full_no_ready", {7'd0, LD_READY}, 8'h00);
        @(posedge CLK);
        #1;
        LD_VALID = 1'b0;
        @(negedge CLK);
        chk_ctl("full_after", 1'b1, 1'b0, 1'b0);
        fetch_all(1'b1);
        chk_sum("full", ck);

        // Full load with random gaps in LD_VALID
        pulse_start();
        ck = 8'h00;
        for (int i = 0; i < 64; i++) begin
            send_byte(8'(i) ^ 8'h5A, 1'b0, 3);
            model[i] = 8'(i) ^ 8'h5A;
            ck = ck + model[i];
        end
        chk_ctl("bp_done", 1'b1, 1'b0, 1'b0);
        fetch_all(1'b1);
        chk_sum("bp", ck);

        // Reload from RUN with a single byte
        pulse_start();
        chk_ctl("reload_start", 1'b0, 1'b1, 1'b1);
        fetch_chk(6'd0, 8'h00);
        fetch_chk(6'd5, 8'h00);
        send_byte(8'h55, 1'b1, 0);
        model[0] = 8'h55;
        chk_ctl("reload_done", 1'b1, 1'b0, 1'b0);
        fetch_all(1'b1);
        chk_sum("reload", 8'h55);

        // LD_START colliding with LD_VALID after three nibbles
        pulse_start();
        send_nib(4'h1, 1'b0, 0);
        send_nib(4'h2, 1'b0, 0);
        send_nib(4'h3, 1'b0, 0);
        LD_START  = 1'b1;
        LD_VALID  = 1'b1;
        LD_NIBBLE = 4'h7;
        #1;
        chk("collide_ready", {7'd0, LD_READY}, 8'h00);
        @(posedge CLK);
        #1;
        LD_START = 1'b0;
        LD_VALID = 1'b0;
        @(negedge CLK);
        chk_ctl("collide_after", 1'b0, 1'b1, 1'b1);
        send_byte(8'h98, 1'b1, 0);
        model[0] = 8'h98;
        chk_ctl("collide_done", 1'b1, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) fetch_chk(6'(a), model[a]);
        chk_sum("collide", 8'h98);

        // RESET in the middle of a load
        pulse_start();
        send_byte(8'hEE, 1'b0, 0);
        send_nib(4'h4, 1'b0, 0);
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        @(negedge CLK);
        chk_ctl("midreset", 1'b0, 1'b0, 1'b0);
        fetch_chk(6'd0, 8'h00);
        chk_sum("midreset", 8'h00);
        for (int a = 0; a < 64; a++) model[a] = 8'h00;
        pulse_start();
        send_byte(8'h11, 1'b1, 0);
        model[0] = 8'h11;
        chk_ctl("midreset_done", 1'b1, 1'b0, 1'b0);
        fetch_all(1'b1);
        chk_sum("midreset_load", 8'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
